// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/period meter: period FSM encoding and
// helpers that derive counter widths from the gate length.
// Latency: n/a (types and constants only). Backpressure: none.
package freq_meter_pkg;

    // Period measurement FSM: idle until a first edge, then time to the next one.
    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } per_state_e;

    // Gate counter runs 0..def_freq-1.
    function automatic int gate_w(input int def_freq);
        return (def_freq > 2) ? $clog2(def_freq) : 1;
    endfunction

    // per_cnt reaches def_freq exactly (timeout point), so it needs one more code.
    function automatic int per_w(input int def_freq);
        return $clog2(def_freq + 1);
    endfunction

    localparam int DEF_FREQ_DFLT = 27000000;
    localparam int GATE_W_DFLT   = gate_w(DEF_FREQ_DFLT);
    localparam int PER_W_DFLT    = per_w(DEF_FREQ_DFLT);

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Synchronizes an asynchronous level into clk and flags its rising edges.
// Latency: SYNC_STAGES cycles to sync_out; rise is combinational from the last stage.
// Backpressure: none; every sampled edge is reported once.
// Ports: clk, rst (async active-low), async_in -> sync_out (synced level),
//        rise (one-cycle pulse on a synced 0->1 transition).
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // sync_q[0] is the metastability-exposed stage; the MSB is the clean one.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Measures an async input: rising edges per DEF_FREQ-cycle gate and clk cycles between edges.
// Latency: input edge reaches counters SYNC_STAGES+1 edges after capture; outputs registered.
// Backpressure: none; freq_valid/period_valid are unconditional one-cycle pulses.
// Ports: clk, rst (async active-low), sig_in (async) -> freq/freq_valid, period/period_valid,
//        no_signal (last completed gate saw no edges).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int DEF_FREQ    = 27000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             no_signal
);

    localparam int GATE_W = gate_w(DEF_FREQ);
    localparam int PER_W  = per_w(DEF_FREQ);

    logic rise;
    logic sync_unused;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .sync_out (sync_unused),
        .rise     (rise)
    );

    // ---------------- gate window / edge counting ----------------
    logic [GATE_W-1:0] g_q, g_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              freq_vld_q, freq_vld_d;
    logic              no_sig_q, no_sig_d;
    logic              gate_last;
    logic [CNT_W-1:0]  edge_sum;

    always_comb begin
        gate_last  = (g_q == GATE_W'(DEF_FREQ - 1));
        // Include this cycle's rise so an edge on the final gate cycle is not lost.
        edge_sum   = edge_cnt_q + CNT_W'(rise);
        g_d        = gate_last ? '0 : g_q + GATE_W'(1);
        edge_cnt_d = edge_sum;
        freq_d     = freq_q;
        freq_vld_d = 1'b0;
        no_sig_d   = no_sig_q;
        if (gate_last) begin
            edge_cnt_d = '0;
            freq_d     = edge_sum;
            freq_vld_d = 1'b1;
            no_sig_d   = (edge_sum == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q        <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            freq_vld_q <= 1'b0;
            no_sig_q   <= 1'b0;
        end else begin
            g_q        <= g_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            freq_vld_q <= freq_vld_d;
            no_sig_q   <= no_sig_d;
        end
    end

    // ---------------- period FSM ----------------
    per_state_e       state_q, state_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             per_vld_q, per_vld_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WAIT_FIRST;
            per_cnt_q <= '0;
            period_q  <= '0;
            per_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            per_vld_q <= per_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        per_vld_d = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    state_d   = MEASURE;
                    per_cnt_d = PER_W'(1);
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle still closes a valid measurement.
                if (rise) begin
                    period_d  = CNT_W'(per_cnt_q);
                    per_vld_d = 1'b1;
                    per_cnt_d = PER_W'(1);
                end else if (per_cnt_q == PER_W'(DEF_FREQ)) begin
                    state_d  = WAIT_FIRST;
                    period_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + PER_W'(1);
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    assign freq         = freq_q;
    assign freq_valid   = freq_vld_q;
    assign period       = period_q;
    assign period_valid = per_vld_q;
    assign no_signal    = no_sig_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table of periodic waves, hand-written corner
// sequences and random segments, all scored every cycle against a timestamp-based model.
module tb_freq_meter;
    localparam int DF = 100;
    localparam int CW = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] freq, period;
    logic          freq_valid, period_valid, no_signal;

    int total = 0;
    int bad   = 0;

    freq_meter #(.DEF_FREQ(DF), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .freq         (freq),
        .freq_valid   (freq_valid),
        .period       (period),
        .period_valid (period_valid),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on timestamps: c counts clk edges since reset release, s[c] is sig_in
    // seen at edge c. The synchronizer delays the level by SS cycles and the edge
    // detector compares against one more, so a rise during cycle c means
    // s[c-SS]==1 and s[c-SS-1]==0 (levels before release read as 0).
    bit   sq[$];
    bit   rq[$];
    bit   armed;
    int   last_rise;
    int   m_freq, m_period;
    bit   m_fv, m_pv, m_ns;
    int   pv_cnt, first_pv_per, fv_first_c;
    int   fv_list[$];

    function automatic bit lvl(input int idx);
        return (idx >= 0) ? sq[idx] : 1'b0;
    endfunction

    always begin
        bit smp, rs_n, rs;
        int c, n;
        @(posedge clk);
        smp  = sig_in;
        rs_n = rst;
        #1;
        if (!rs_n) begin
            sq.delete(); rq.delete(); fv_list.delete();
            armed = 0; last_rise = 0;
            m_freq = 0; m_period = 0; m_fv = 0; m_pv = 0; m_ns = 0;
            pv_cnt = 0; first_pv_per = -1; fv_first_c = -1;
            chk("reset_outputs", {freq, freq_valid, period, period_valid, no_signal}, '0);
        end else begin
            c = sq.size();
            sq.push_back(smp);
            rs = lvl(c - SS) && !lvl(c - SS - 1);
            rq.push_back(rs);
            m_fv = 0;
            if (c % DF == DF - 1) begin
                n = 0;
                for (int i = c - DF + 1; i <= c; i++) n += int'(rq[i]);
                m_freq = n; m_fv = 1; m_ns = (n == 0);
            end
            m_pv = 0;
            if (rs) begin
                if (armed) begin m_period = c - last_rise; m_pv = 1; end
                armed = 1; last_rise = c;
            end else if (armed && (c - last_rise == DF)) begin
                armed = 0; m_period = 0;
            end
            chk("outputs", {freq, freq_valid, period, period_valid, no_signal},
                {CW'(m_freq), m_fv, CW'(m_period), m_pv, m_ns});
            if (period_valid) begin
                if (pv_cnt == 0) first_pv_per = int'(period);
                pv_cnt++;
            end
            if (freq_valid) begin
                if (fv_first_c < 0) fv_first_c = c;
                fv_list.push_back(int'(freq));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // hi+lo==0 selects per-cycle random noise; otherwise a wave hi high / lo low.
    task automatic drive(input int n, input int hi, input int lo, input int ph);
        for (int k = 0; k < n; k++) begin
            if (hi + lo == 0) sig_in = 1'($urandom_range(0, 1));
            else              sig_in = (((k + ph) % (hi + lo)) < hi);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_freq;
        int exp_period;
        bit exp_ns;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{hi: 5,  lo: 5,  exp_freq: 10, exp_period: 10, exp_ns: 0};
        vt[1] = '{hi: 1,  lo: 1,  exp_freq: 50, exp_period: 2,  exp_ns: 0};
        vt[2] = '{hi: 2,  lo: 2,  exp_freq: 25, exp_period: 4,  exp_ns: 0};
        vt[3] = '{hi: 2,  lo: 3,  exp_freq: 20, exp_period: 5,  exp_ns: 0};
        vt[4] = '{hi: 10, lo: 10, exp_freq: 5,  exp_period: 20, exp_ns: 0};
        vt[5] = '{hi: 20, lo: 30, exp_freq: 2,  exp_period: 50, exp_ns: 0};
        vt[6] = '{hi: 0,  lo: 1,  exp_freq: 0,  exp_period: 0,  exp_ns: 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_freq", freq, 0);
        chk("rst_freq_valid", freq_valid, 0);
        chk("rst_period", period, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_no_signal", no_signal, 0);
        rst = 1'b1;

        // Table of periodic waves, steady state after three windows
        foreach (vt[i]) begin
            do_reset();
            drive(350, vt[i].hi, vt[i].lo, 0);
            chk($sformatf("tbl%0d_freq", i), freq, vt[i].exp_freq);
            chk($sformatf("tbl%0d_period", i), period, vt[i].exp_period);
            chk($sformatf("tbl%0d_no_signal", i), no_signal, vt[i].exp_ns);
        end

        // Constant low: two windows closed, no period pulses
        do_reset();
        drive(250, 0, 1, 0);
        chk("low_fv_count", fv_list.size(), 2);
        chk("low_pv_count", pv_cnt, 0);

        // Single pulse then silence, then a rise every 7 cycles
        do_reset();
        drive(150, 3, 1000, 0);
        chk("pulse_pv_count", pv_cnt, 0);
        chk("pulse_period", period, 0);
        drive(40, 1, 6, 0);
        chk("p7_seen", (pv_cnt > 0), 1);
        chk("p7_first_period", first_pv_per, 7);

        // Timeout boundary: edges exactly DF apart are measured, DF+1 apart are not
        do_reset();
        drive(350, 1, DF - 1, 0);
        chk("gap_df_period", period, DF);
        chk("gap_df_pv_seen", (pv_cnt >= 2), 1);
        do_reset();
        drive(350, 1, DF, 0);
        chk("gap_df1_pv_count", pv_cnt, 0);
        chk("gap_df1_period", period, 0);

        // Rise on the last gate cycle counts in the closing window
        do_reset();
        drive(DF - 1 - SS, 0, 1, 0);
        drive(200, 1, 0, 0);
        chk("last_cycle_windows", (fv_list.size() >= 2), 1);
        if (fv_list.size() >= 2) begin
            chk("last_cycle_freq0", fv_list[0], 1);
            chk("last_cycle_freq1", fv_list[1], 0);
        end

        // Mid-window reset during the 10-cycle wave
        do_reset();
        drive(50, 5, 5, 0);
        rst = 1'b0;
        #1;
        chk("midrst_outputs_clear", {freq, freq_valid, period, period_valid, no_signal}, '0);
        drive(3, 5, 5, 50);
        rst = 1'b1;
        drive(250, 5, 5, 53);
        chk("midrst_first_fv_cycle", fv_first_c, DF - 1);
        chk("midrst_freq_range", (freq >= 9 && freq <= 11), 1);

        // Random segments, scored cycle by cycle
        do_reset();
        for (int s = 0; s < 10; s++)
            drive($urandom_range(100, 300), $urandom_range(0, 12),
                  $urandom_range(0, 12), $urandom_range(0, 20));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures an external asynchronous digital signal against the system clock: rising edges per gate window (frequency) and clk cycles between consecutive rising edges (period). It is the measurement counterpart of the clock divider: it consumes slow external or divided clocks and interrupt lines and reports their rate to the rest of the design. It also flags a dead input via `no_signal`.

## Interface
- `DEF_FREQ`, default 27000000: clk cycles per gate window, which is 1 s at 27 MHz; must be ≥ 4.
- `CNT_W`, default 32: width of `freq` and `period`; must be ≥ $clog2(DEF_FREQ+1).
- `SYNC_STAGES`, default 2: synchronizer depth; must be ≥ 2.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `sig_in`, input, 1: asynchronous signal under measurement.
- `freq`, output, CNT_W: rising edges counted in the last completed gate window.
- `freq_valid`, output, 1: one-cycle pulse when `freq` updates.
- `period`, output, CNT_W: clk cycles between the last two rising edges; 0 after a timeout.
- `period_valid`, output, 1: one-cycle pulse when `period` updates with a measurement.
- `no_signal`, output, 1: high if the last completed gate window saw zero rising edges.

## Operation
- **Reset values:** all outputs 0, synchronizer flops 0, gate counter 0, FSM in WAIT_FIRST.
- **Synchronizer and edge detection:** `sig_in` passes through SYNC_STAGES flops, then one `prev` flop. `rise` = last sync stage AND NOT `prev`, combinational. All downstream logic uses only `rise`.
- **Gate counter:** `g` runs 0..DEF_FREQ-1, increments every cycle and wraps to 0. Width is $clog2(DEF_FREQ).
- **Edge counter:** increments on `rise`.
- **At the clock edge where g == DEF_FREQ-1:**
  - `freq` <= edge_cnt + rise, so a rise in the last cycle counts in the closing window.
  - edge_cnt <= 0.
  - `freq_valid` <= 1.
  - `no_signal` <= (edge_cnt + rise == 0).
- **`freq_valid` otherwise:** 0.
- **Period FSM, state WAIT_FIRST:** on `rise`, go to MEASURE with per_cnt <= 1. Otherwise stay.
- **Period FSM, state MEASURE, on `rise`:** `period` <= per_cnt, `period_valid` <= 1, per_cnt <= 1.
- **Period FSM, state MEASURE, timeout:** if there is no rise and per_cnt == DEF_FREQ, go to WAIT_FIRST with `period` <= 0 and no `period_valid` pulse.
- **Period FSM, state MEASURE, otherwise:** per_cnt <= per_cnt + 1.
- **Rise and timeout in the same cycle:** rise wins; the measurement is taken.
- **per_cnt range:** never exceeds DEF_FREQ, so no wrap is possible.
- **Maximum measurable rate:** a rise every 2 clk cycles, giving `freq` = DEF_FREQ/2 and `period` = 2. Faster input aliases, which is acceptable and undetected.

## Timing
- **Input latency:** a `sig_in` rising transition meeting setup before clk edge N produces `rise` during the cycle after edge N+SYNC_STAGES-1. Counters and outputs update at edge N+SYNC_STAGES.
- **Period accuracy:** the latency is constant, so `period` is exact for an ideal periodic input, ±1 cycle for an asynchronous one.
- **First `freq_valid`:** exactly DEF_FREQ cycles after reset release; thereafter every DEF_FREQ cycles.
- **`period_valid`:** registered; asserted in the cycle after the rise that closes the measurement.
- **Output stability:** outputs hold between updates.
- **Reset mid-operation:** immediate clear of all state. The partial window is discarded, and the gate restarts at 0 on release.

## Structure
- Shared package/header `freq_meter_pkg`:
  - FSM encoding: WAIT_FIRST = 1'b0, MEASURE = 1'b1.
  - Derived width localparams for the gate counter and per_cnt.
- One sub-module, `edge_sync`, with ports clk, rst, async_in, sync_out, rise. It holds the synchronizer and `prev` flop. It is reused by the external-interrupt input path.
- Top level contains the gate counter, edge counter, period FSM and output registers.

## Test plan
All scenarios use DEF_FREQ=100, CNT_W=16, SYNC_STAGES=2.
- **Square wave:** 10-cycle period, 50% duty, phase aligned to clk -> `freq` = 10 at every `freq_valid` from the second window on; `period` = 10 with `period_valid` every 10 cycles; `no_signal` = 0.
- **Constant low for 250 cycles:** -> `freq_valid` at cycles 100 and 200 with `freq` = 0; `no_signal` = 1 after the first; `period_valid` never asserts.
- **Maximum rate:** `sig_in` toggles every cycle -> `freq` = 50, `period` = 2.
- **Single pulse then silence:** -> no `period_valid`; exactly 100 cycles after the rise, FSM returns to WAIT_FIRST and `period` = 0. Then a rise every 7 cycles -> the first `period_valid` comes on the second rise with `period` = 7.
- **Rise on the last gate cycle:** `rise` in the cycle where g = 99 -> that edge counts in the closing window's `freq`, and the next window's count starts at 0.
- **Mid-window reset:** rst low for 3 cycles at g = 50 during the 10-cycle wave -> all outputs 0 immediately; the next `freq_valid` comes 100 cycles after release with `freq` = 10 (±1 for phase).
